// File: rtl/toggle_event_decoder_pkg.sv
// Shared types and default constants for the toggle event decoder.
package toggle_event_decoder_pkg;

    typedef enum logic [0:0] {
        StPrime,
        StRun
    } state_e;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefCntW       = 4;
    localparam int unsigned DefFiltCycles = 3;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for the asynchronous toggle input.
module toggle_sync
    import toggle_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes a T flip-flop level into event pulses with a pending-event counter.
// Optional glitch filter compiled in by defining TOGGLE_EVENT_DECODER_FILTER_EN.
module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned FILT_CYCLES = DefFiltCycles
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    output logic             t_level,
    output logic             ev_pulse,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] ev_pending,
    output logic             ev_overflow,
    input  logic             ovf_clr
);

    // Sized for the filtered build so both builds share one counter definition.
    localparam int unsigned PrimeW = $clog2(SYNC_STAGES + FILT_CYCLES + 2);

    logic raw_lvl;
    logic lvl;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (t_in),
        .q    (raw_lvl)
    );

`ifdef TOGGLE_EVENT_DECODER_FILTER_EN
    localparam int unsigned FiltW       = $clog2(FILT_CYCLES + 1);
    // Priming also covers the filter delay so a static high level raises no event.
    localparam int unsigned PrimeCycles = SYNC_STAGES + 1 + FILT_CYCLES;

    logic             filt_q, filt_d;
    logic [FiltW-1:0] fcnt_q, fcnt_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (raw_lvl != filt_q) begin
            if (fcnt_q == FiltW'(FILT_CYCLES - 1)) begin
                filt_d = raw_lvl;
            end else begin
                fcnt_d = fcnt_q + FiltW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    localparam int unsigned PrimeCycles = SYNC_STAGES + 1;

    assign lvl = raw_lvl;
`endif

    state_e              state_q, state_d;
    logic [PrimeW-1:0]   prime_cnt_q, prime_cnt_d;
    logic                prev_q, prev_d;
    logic                edge_det;
    logic                pulse_q;
    logic [CNT_W-1:0]    pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                take;
    logic                full;

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        prev_d      = prev_q;
        edge_det    = 1'b0;
        case (state_q)
            StPrime: begin
                prev_d      = lvl;
                prime_cnt_d = prime_cnt_q + PrimeW'(1);
                if (prime_cnt_q == PrimeW'(PrimeCycles - 1)) begin
                    state_d     = StRun;
                    prime_cnt_d = '0;
                end
            end
            StRun: begin
                if (lvl != prev_q) begin
                    edge_det = 1'b1;
                    prev_d   = lvl;
                end
            end
            default: state_d = StPrime;
        endcase
    end

    assign take = ev_valid && ev_ready;
    assign full = (pend_q == '1);

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // Simultaneous increment and take cancel out.
        if (edge_det && !take) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (take && !edge_det) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StPrime;
            prime_cnt_q <= '0;
            prev_q      <= 1'b0;
            pulse_q     <= 1'b0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prev_q      <= prev_d;
            pulse_q     <= edge_det;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign t_level     = lvl;
    assign ev_pulse    = pulse_q;
    assign ev_pending  = pend_q;
    assign ev_valid    = (pend_q != '0);
    assign ev_overflow = ovf_q;

endmodule
